cla_nibble_serial_adder: RTL and testbench

- Multi-cycle WIDTH-bit adder/subtractor built around one 4-bit carry-lookahead slice.
- Processes one nibble per clock, least significant nibble first, with a registered carry chain between nibbles.
- Sits one stage downstream of the operand source and wraps the 4-bit CLA slice to provide wide arithmetic with valid/ready handshakes on both sides.
- Produces sum, carry-out, signed overflow and zero flags.

---
 rtl/cla_nibble_serial_adder.sv | 167 ++++++++++++++++
 tb/tb_cla_nibble_serial_adder.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_nibble_serial_adder.sv
// ---------------------------------------------------------------------------
// cla_nibble_serial_adder
//
// Multi-cycle WIDTH-bit adder/subtractor built around a single 4-bit
// carry-lookahead slice. Operands are latched on a valid/ready handshake,
// then one nibble is processed per clock (least significant first) with the
// carry held in a register between nibbles. The result is presented with a
// valid/ready handshake and held for as long as the consumer stalls.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   operand set valid
//   in_ready   block can accept operands (IDLE and not in reset)
//   X, Y       WIDTH-bit operands
//   Cin        carry-in, used only for addition
//   sub        1 = X-Y, 0 = X+Y+Cin
//   out_valid  result valid (DONE state)
//   out_ready  consumer accepts result
//   S          WIDTH-bit result
//   Cout       carry out of the MSB (for subtraction, 1 = no borrow)
//   OF         signed overflow
//   Z          result equals zero
//   busy       an operation is in flight or awaiting handoff
// ---------------------------------------------------------------------------
module cla_nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             OF,
    output logic             Z,
    output logic             busy
);

    localparam int NIBS = WIDTH / 4;
    localparam int IDXW = (NIBS > 1) ? $clog2(NIBS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [IDXW-1:0]  idx;
    logic             carry;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;

    logic [IDXW+1:0]  base;
    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [3:0]       p;
    logic [3:0]       g;
    logic [4:0]       c;
    logic [3:0]       nib_sum;
    logic [WIDTH-1:0] s_next;

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    // Bit offset of the nibble currently being processed.
    assign base = {idx, 2'b00};

    // 4-bit carry-lookahead slice: every internal carry is a flat
    // generate/propagate expression of the registered carry-in, so the
    // slice has no rippling between its bits.
    always_comb begin
        a_nib   = a_reg[base +: 4];
        b_nib   = b_reg[base +: 4];
        p       = a_nib ^ b_nib;
        g       = a_nib & b_nib;
        c[0]    = carry;
        c[1]    = g[0] | (p[0] & c[0]);
        c[2]    = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3]    = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
        c[4]    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);
        nib_sum = p ^ c[3:0];
    end

    // Result as it will look after this edge; used so the zero flag sees
    // the final nibble in the same cycle it is written.
    always_comb begin
        s_next            = S;
        s_next[base +: 4] = nib_sum;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: accept in IDLE, walk the nibbles in CALC, hold the
    // result in DONE until the consumer takes it.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (in_valid && in_ready) next_state = CALC;
            CALC: if (idx == LAST_IDX)      next_state = DONE;
            DONE: if (out_ready)            next_state = IDLE;
            default:                        next_state = IDLE;
        endcase
    end

    // Datapath. Subtraction is folded into addition by inverting Y and
    // forcing the initial carry to 1, which also makes Cout read as
    // "no borrow". Outside reset in_ready equals (state == IDLE), so the
    // IDLE branch only needs in_valid to recognise an accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx   <= '0;
            carry <= 1'b0;
            a_reg <= '0;
            b_reg <= '0;
            S     <= '0;
            Cout  <= 1'b0;
            OF    <= 1'b0;
            Z     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= X;
                        b_reg <= sub ? ~Y : Y;
                        carry <= sub ? 1'b1 : Cin;
                        idx   <= '0;
                    end
                end
                CALC: begin
                    S     <= s_next;
                    carry <= c[4];
                    if (idx == LAST_IDX) begin
                        Cout <= c[4];
                        OF   <= c[3] ^ c[4];
                        Z    <= (s_next == '0);
                    end else begin
                        idx <= idx + IDXW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_cla_nibble_serial_adder
//
// Self-checking bench for cla_nibble_serial_adder (WIDTH=16). Directed
// vectors come from a table with hand-derived expectations; the carry-in
// sweep and the random operations are checked against a plain-arithmetic
// reference model. Reset-in-flight and backpressure are exercised by
// hand-written sequences.
// ---------------------------------------------------------------------------
module tb_cla_nibble_serial_adder;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] X;
    logic [W-1:0] Y;
    logic         Cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] S;
    logic         Cout;
    logic         OF;
    logic         Z;
    logic         busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         cin;
        logic         sb;
        logic [W-1:0] s;
        logic         cout;
        logic         of;
        logic         z;
    } vec_t;

    vec_t vecs[7];

    cla_nibble_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .X         (X),
        .Y         (Y),
        .Cin       (Cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .Cout      (Cout),
        .OF        (OF),
        .Z         (Z),
        .busy      (busy)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Hard stop if something never completes.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison with bookkeeping.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Reference model: true integer arithmetic on the operands.
    // Returns {z, of, cout, s}.
    function automatic logic [W+2:0] refModel(input logic [W-1:0] x,
                                              input logic [W-1:0] y,
                                              input logic cin, input logic sb);
        longint ux;
        longint uy;
        longint sx;
        longint sy;
        longint ures;
        longint sres;
        logic [W-1:0] s;
        logic cout;
        logic of;
        ux = longint'(x);
        uy = longint'(y);
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (sb) begin
            ures = ux - uy;
            sres = sx - sy;
            cout = (ux >= uy);
        end else begin
            ures = ux + uy + longint'(cin);
            sres = sx + sy + longint'(cin);
            cout = (ures >= 65536);
        end
        s  = ures[W-1:0];
        of = (sres > 32767) || (sres < -32768);
        return {(s == '0), of, cout, s};
    endfunction

    // Full transaction: present operands, wait for acceptance, check
    // latency and results, stall the consumer, then hand the result off.
    task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic cin, input logic sb,
                                 input int stall,
                                 input logic [W-1:0] es, input logic ec,
                                 input logic eo, input logic ez,
                                 input logic hold_valid);
        int n;
        int lat;
        X         = x;
        Y         = y;
        Cin       = cin;
        sub       = sb;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            errors++;
            $display("[TB] FAIL accept_timeout: in_ready got 0, expected 1");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (!hold_valid) in_valid = 1'b0;
        X   = W'($urandom);
        Y   = W'($urandom);
        Cin = 1'($urandom);
        sub = 1'($urandom);
        checkOutput("busy_after_accept", busy, 1);
        lat = 0;
        while (!out_valid && lat < 40) begin
            checkOutput("in_ready_calc", in_ready, 0);
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("latency", lat, 4);
        checkOutput("S", S, es);
        checkOutput("Cout", Cout, ec);
        checkOutput("OF", OF, eo);
        checkOutput("Z", Z, ez);
        for (int k = 0; k < stall; k++) begin
            @(posedge clk);
            #1;
            checkOutput("stall_out_valid", out_valid, 1);
            checkOutput("stall_in_ready", in_ready, 0);
            checkOutput("stall_S", S, es);
            checkOutput("stall_flags", {Cout, OF, Z}, {ec, eo, ez});
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("out_valid_drop", out_valid, 0);
        checkOutput("in_ready_after_done", in_ready, 1);
        checkOutput("S_retained", S, es);
    endtask

    initial begin
        logic [W+2:0] r;
        logic [W-1:0] rx;
        logic [W-1:0] ry;
        logic         rc;
        logic         rs;

        // Directed vectors with hand-derived results.
        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        X         = '0;
        Y         = '0;
        Cin       = 1'b0;
        sub       = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_in_ready", in_ready, 0);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_S", S, 0);
        checkOutput("reset_flags", {Cout, OF, Z}, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("post_reset_in_ready", in_ready, 1);

        // Directed table; the first entry also gets a 10-cycle stall.
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].x, vecs[i].y, vecs[i].cin, vecs[i].sb,
                          (i == 0) ? 10 : 0,
                          vecs[i].s, vecs[i].cout, vecs[i].of, vecs[i].z, 1'b0);
        end

        // Carry-in sweep with in_valid held high between operations.
        for (int j = 0; j <= 14; j++) begin
            rx = W'(j);
            ry = W'(15 - 2 * j);
            r  = refModel(rx, ry, 1'b1, 1'b0);
            applyStimulus(rx, ry, 1'b1, 1'b0, 0, r[W-1:0], r[W], r[W+1], r[W+2], 1'b1);
        end
        in_valid = 1'b0;

        // Reset while the second nibble has just been computed.
        X        = 16'h1234;
        Y        = 16'h1111;
        Cin      = 1'b0;
        sub      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("rst_test_busy", busy, 1);
        @(posedge clk);
        @(posedge clk);
        #2;
        checkOutput("rst_test_partial_S", S, 16'h0045);
        rst = 1'b1;
        #1;
        checkOutput("midrst_S", S, 0);
        checkOutput("midrst_flags", {Cout, OF, Z}, 3'b000);
        checkOutput("midrst_out_valid", out_valid, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_in_ready", in_ready, 0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            checkOutput("midrst_hold_out_valid", out_valid, 0);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            checkOutput("after_rst_out_valid", out_valid, 0);
            checkOutput("after_rst_in_ready", in_ready, 1);
        end
        applyStimulus(16'h1234, 16'h1111, 1'b0, 1'b0, 2, 16'h2345, 1'b0, 1'b0, 1'b0, 1'b0);

        // Randomised operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            rx = W'($urandom);
            ry = W'($urandom);
            rc = 1'($urandom);
            rs = 1'($urandom);
            if (i % 8 == 0) ry = ~rx;
            r = refModel(rx, ry, rc, rs);
            applyStimulus(rx, ry, rc, rs, int'($urandom_range(0, 3)),
                          r[W-1:0], r[W], r[W+1], r[W+2], 1'($urandom));
            in_valid = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
